// File: rtl/ahb_sram_sub.sv
// ahb_sram_sub
//
// AHB-Lite subordinate backed by an internal word-addressed storage array.
// It serves as a scratchpad and as the reference target for interconnect
// checks. Storage contents are not reset.
//
// Parameters
//   DATA_W      : data bus width, 32 or 64
//   ADDR_W      : HADDR width
//   DEPTH       : number of DATA_W words; need not be a power of two
//   WAIT_STATES : HREADYOUT-low cycles at the start of every OKAY data phase, 0..15
//
// Ports
//   HCLK, HRESETn : clock and asynchronous active-low reset
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE : address phase
//   HWDATA        : write data, valid in the data phase
//   HREADY        : bus-wide ready; a phase ends on an edge where it is high
//   HRDATA        : read data; zero except in the final cycle of a read
//   HREADYOUT     : subordinate ready
//   HRESP         : OKAY (0) or ERROR (1)
//   sub_state     : current state, IDLE=0 READ=1 WRITE=2 ERROR=3
//
// Handshake: a transfer is accepted on a rising edge where
// HSEL & HREADY & HTRANS is NONSEQ/SEQ and this subordinate is itself ready.
// The data phase ends on the first edge where both HREADYOUT and HREADY are 1.
//
// Optional build macro AHB_SRAM_SUB_ALIGN_CHECK_EN: when defined, a byte
// offset not aligned to HSIZE is answered with ERROR. When undefined the
// offset is aligned down and the transfer completes OKAY.

module ahb_sram_sub #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic [1:0]        HRESP,
    output logic [1:0]        sub_state
);

    localparam int         BYTES    = DATA_W / 8;
    localparam int         OFF_W    = $clog2(BYTES);
    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              err2_q, err2_d;      // second ERROR cycle
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [2:0]        size_q, size_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready_int;
    logic              phase_end;
    logic              trans_active;
    logic              accept;
    logic [ADDR_W-1:0] word_addr;
    logic              idx_bad;
    logic              size_bad;
    logic              misaligned;
    logic              mem_we;
    logic [BYTES-1:0]  lane_en;

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    assign trans_active = (HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ);
    assign word_addr    = HADDR >> OFF_W;
    assign idx_bad      = (word_addr >= ADDR_W'(DEPTH));
    assign size_bad     = (HSIZE > MAX_SIZE);

`ifdef AHB_SRAM_SUB_ALIGN_CHECK_EN
    logic [OFF_W-1:0] size_mask;

    always_comb begin
        size_mask = '0;
        for (int i = 0; i < OFF_W; i++) begin
            size_mask[i] = (3'(i) < HSIZE);
        end
    end

    assign misaligned = |(HADDR[OFF_W-1:0] & size_mask);
`else
    assign misaligned = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs, all decoded from registered state
    // ------------------------------------------------------------------
    always_comb begin
        ready_int = 1'b1;
        case (state_q)
            S_READ, S_WRITE: ready_int = (wait_q == 4'd0);
            S_ERROR:         ready_int = err2_q;
            default:         ready_int = 1'b1;
        endcase
    end

    assign HREADYOUT = ready_int;
    assign HRESP     = (state_q == S_ERROR) ? RESP_ERROR : RESP_OKAY;
    assign HRDATA    = (state_q == S_READ && wait_q == 4'd0) ? mem[idx_q] : '0;
    assign sub_state = state_q;

    assign phase_end = ready_int & HREADY;
    assign accept    = phase_end & HSEL & trans_active;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err2_d  = err2_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        mem_we  = 1'b0;

        if ((state_q == S_READ || state_q == S_WRITE) && wait_q != 4'd0) begin
            wait_d = wait_q - 4'd1;
        end
        if (state_q == S_ERROR && !err2_q) begin
            err2_d = 1'b1;
        end

        if (phase_end) begin
            // The write commits on the same edge that may load a new index,
            // so a back-to-back read of the same word sees the new data.
            mem_we = (state_q == S_WRITE);
            err2_d = 1'b0;
            if (accept) begin
                idx_d  = word_addr[IDX_W-1:0];
                off_d  = HADDR[OFF_W-1:0];
                size_d = HSIZE;
                wait_d = 4'(WAIT_STATES);
                if (idx_bad || size_bad || misaligned) begin
                    state_d = S_ERROR;
                end else if (HWRITE) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            wait_q  <= 4'd0;
            err2_q  <= 1'b0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err2_q  <= err2_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage with byte-lane writes. A lane is written when it falls in the
    // same HSIZE-aligned block as the byte offset, which aligns the offset
    // down to the transfer size.
    // ------------------------------------------------------------------
    always_comb begin
        lane_en = '0;
        for (int b = 0; b < BYTES; b++) begin
            lane_en[b] = ((OFF_W'(b) >> size_q) == (off_q >> size_q));
        end
    end

    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (lane_en[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_sub.sv
// tb_ahb_sram_sub
//
// Directed bench for ahb_sram_sub. Three instances share the address/data
// bus; each has its own HSEL and its HREADY looped back from its HREADYOUT
// (optionally forced low to model another subordinate stalling).
//   u_dut0 : WAIT_STATES=0
//   u_dut3 : WAIT_STATES=3
//   u_dut2 : WAIT_STATES=2
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at that same point, away from the edge.

module tb_ahb_sram_sub;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic             clk;
    logic             rst_n;
    logic [2:0]       hsel;
    logic [31:0]      haddr;
    logic [1:0]       htrans;
    logic             hwrite;
    logic [2:0]       hsize;
    logic [31:0]      hwdata;
    logic [2:0]       hready;
    logic [2:0]       hold_low;
    logic [2:0][31:0] rdata;
    logic [2:0]       readyout;
    logic [2:0][1:0]  resp;
    logic [2:0][1:0]  st;

    int n_checks;
    int n_errors;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign hready[0] = hold_low[0] ? 1'b0 : readyout[0];
    assign hready[1] = hold_low[1] ? 1'b0 : readyout[1];
    assign hready[2] = hold_low[2] ? 1'b0 : readyout[2];

    ahb_sram_sub #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready[0]),
        .HRDATA(rdata[0]), .HREADYOUT(readyout[0]), .HRESP(resp[0]), .sub_state(st[0])
    );

    ahb_sram_sub #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_STATES(3)) u_dut3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready[1]),
        .HRDATA(rdata[1]), .HREADYOUT(readyout[1]), .HRESP(resp[1]), .sub_state(st[1])
    );

    ahb_sram_sub #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_STATES(2)) u_dut2 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready[2]),
        .HRDATA(rdata[2]), .HREADYOUT(readyout[2]), .HRESP(resp[2]), .sub_state(st[2])
    );

    // ------------------------------------------------------------------
    // Checker
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic addr(input int d, input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel      = 3'b000;
        hsel[d]   = 1'b1;
        haddr     = a;
        htrans    = T_NONSEQ;
        hwrite    = w;
        hsize     = sz;
    endtask

    task automatic idle_bus();
        hsel   = 3'b000;
        htrans = T_IDLE;
        hwrite = 1'b0;
        haddr  = 32'h0;
        hsize  = 3'd2;
    endtask

    // Runs through waited cycles of instance d. Each cycle entered must show
    // state exp_st; reports number of HREADYOUT-low cycles and whether HRDATA
    // was non-zero or the state wrong while waiting. Bounded to 20 cycles.
    task automatic wait_ready(input int d, input logic [1:0] exp_st,
                              output int lows, output logic bad);
        lows = 0;
        bad  = 1'b0;
        while (!readyout[d] && lows < 20) begin
            if (st[d] != exp_st || rdata[d] != 32'h0 || resp[d] != 2'b00) bad = 1'b1;
            lows++;
            cyc();
        end
        if (st[d] != exp_st) bad = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int   lows;
        logic bad;

        n_checks = 0;
        n_errors = 0;
        hold_low = 3'b000;
        hwdata   = 32'h0;
        idle_bus();
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        // Reset values
        check("rst_ready", readyout[0], 1'b1);
        check("rst_resp",  resp[0],     2'b00);
        check("rst_rdata", rdata[0],    32'h0);
        check("rst_state", st[0],       2'd0);

        // ---------------- WAIT_STATES=0 instance ----------------
        // Seed word 0
        addr(0, 32'h0, 1'b1, 3'd2);
        cyc();
        hwdata = 32'h0102_0304;
        idle_bus();
        cyc();

        // Write 0x10 then back-to-back read 0x10
        addr(0, 32'h10, 1'b1, 3'd2);
        cyc();
        check("raw_wr_state", st[0],       2'd2);
        check("raw_wr_ready", readyout[0], 1'b1);
        hwdata = 32'hDEAD_BEEF;
        addr(0, 32'h10, 1'b0, 3'd2);
        cyc();
        check("raw_rd_state", st[0],       2'd1);
        check("raw_rd_data",  rdata[0],    32'hDEAD_BEEF);
        check("raw_rd_ready", readyout[0], 1'b1);
        check("raw_rd_resp",  resp[0],     2'b00);
        idle_bus();
        cyc();
        check("raw_idle_state", st[0], 2'd0);
        check("idle_rdata",     rdata[0], 32'h0);

        // Byte write 0xAA at 0x13 over 0x11223344
        addr(0, 32'h10, 1'b1, 3'd2);
        cyc();
        hwdata = 32'h1122_3344;
        addr(0, 32'h13, 1'b1, 3'd0);
        cyc();
        hwdata = 32'hAA5A_5A5A;
        addr(0, 32'h10, 1'b0, 3'd2);
        cyc();
        check("byte_wr_data", rdata[0], 32'hAA22_3344);
        idle_bus();
        cyc();

        // Out-of-range write -> two-cycle ERROR, read accepted in cycle 2
        addr(0, 32'h400, 1'b1, 3'd2);
        cyc();
        check("err1_state", st[0],       2'd3);
        check("err1_ready", readyout[0], 1'b0);
        check("err1_resp",  resp[0],     2'b01);
        hwdata = 32'hFFFF_FFFF;
        addr(0, 32'h0, 1'b0, 3'd2);
        cyc();
        check("err2_state", st[0],       2'd3);
        check("err2_ready", readyout[0], 1'b1);
        check("err2_resp",  resp[0],     2'b01);
        cyc();
        check("err_next_state", st[0],    2'd1);
        check("err_next_data",  rdata[0], 32'h0102_0304);
        check("err_next_resp",  resp[0],  2'b00);
        idle_bus();
        cyc();

        // HSIZE=3 on a 32-bit bus -> ERROR
        addr(0, 32'h0, 1'b0, 3'd3);
        cyc();
        check("sz3_err1_state", st[0],       2'd3);
        check("sz3_err1_ready", readyout[0], 1'b0);
        idle_bus();
        cyc();
        check("sz3_err2_ready", readyout[0], 1'b1);
        check("sz3_err2_resp",  resp[0],     2'b01);
        cyc();
        check("sz3_idle_state", st[0], 2'd0);

        // Halfword at 0x1
        addr(0, 32'h1, 1'b1, 3'd1);
        cyc();
`ifdef AHB_SRAM_SUB_ALIGN_CHECK_EN
        check("hw_mis_state", st[0], 2'd3);
        hwdata = 32'h5A5A_CAFE;
        idle_bus();
        cyc();
        cyc();
        addr(0, 32'h0, 1'b0, 3'd2);
        cyc();
        check("hw_mis_data", rdata[0], 32'h0102_0304);
`else
        check("hw_mis_state", st[0], 2'd2);
        check("hw_mis_resp",  resp[0], 2'b00);
        hwdata = 32'h5A5A_CAFE;
        addr(0, 32'h0, 1'b0, 3'd2);
        cyc();
        check("hw_mis_data", rdata[0], 32'h0102_CAFE);
`endif
        idle_bus();
        cyc();

        // HREADY low from another subordinate: no accept
        hold_low[0] = 1'b1;
        addr(0, 32'h10, 1'b0, 3'd2);
        cyc();
        check("hrdy_low_state", st[0],    2'd0);
        check("hrdy_low_rdata", rdata[0], 32'h0);
        hold_low[0] = 1'b0;
        idle_bus();
        cyc();
        check("hrdy_rel_state", st[0], 2'd0);

        // ---------------- WAIT_STATES=3 instance ----------------
        addr(1, 32'h0, 1'b1, 3'd2);
        cyc();
        hwdata = 32'h1357_9BDF;
        idle_bus();
        wait_ready(1, 2'd2, lows, bad);
        check("ws3_wr_lows", lows, 3);
        check("ws3_wr_seq",  bad,  1'b0);
        cyc();
        check("ws3_wr_idle", st[1], 2'd0);

        addr(1, 32'h0, 1'b0, 3'd2);
        cyc();
        idle_bus();
        wait_ready(1, 2'd1, lows, bad);
        check("ws3_rd_lows", lows, 3);
        check("ws3_rd_seq",  bad,  1'b0);
        check("ws3_rd_data", rdata[1], 32'h1357_9BDF);
        check("ws3_rd_resp", resp[1],  2'b00);
        cyc();
        check("ws3_rd_idle", st[1], 2'd0);

        // ---------------- WAIT_STATES=2 instance ----------------
        addr(2, 32'h8, 1'b1, 3'd2);
        cyc();
        hwdata = 32'h0BAD_F00D;
        idle_bus();
        wait_ready(2, 2'd2, lows, bad);
        check("ws2_wr_lows", lows, 2);
        cyc();

        // Reset during a write stall
        addr(2, 32'h8, 1'b1, 3'd2);
        cyc();
        check("ws2_stall_ready", readyout[2], 1'b0);
        hwdata = 32'hFFFF_FFFF;
        idle_bus();
        rst_n = 1'b0;
        cyc();
        check("mid_rst_state", st[2],       2'd0);
        check("mid_rst_ready", readyout[2], 1'b1);
        check("mid_rst_resp",  resp[2],     2'b00);
        check("mid_rst_rdata", rdata[2],    32'h0);
        rst_n = 1'b1;
        cyc();
        cyc();

        addr(2, 32'h8, 1'b0, 3'd2);
        cyc();
        idle_bus();
        wait_ready(2, 2'd1, lows, bad);
        check("ws2_rd_lows", lows, 2);
        check("ws2_rd_data", rdata[2], 32'h0BAD_F00D);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
